// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder with req/ack handshake and probe port
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wd,
  output logic [31:0]           rd,
  output logic                  ack,
  output logic                  busy,
  output logic                  err,
  input  logic [ADDR_WIDTH-1:0] probe_addr,
  output logic [31:0]           probe_data
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [3:0]        WS_L    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                state, state_next;
  logic [3:0]            cnt;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wd_q;
  logic [31:0]           mem [0:DEPTH-1];

  logic             access;
  logic             in_range;
  logic             probe_in;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] probe_idx;

  assign access    = (state == S_WAIT) && (cnt == 4'd0);
  assign in_range  = {1'b0, addr_q} < DEPTH_L;
  assign probe_in  = {1'b0, probe_addr} < DEPTH_L;
  assign idx_q     = addr_q[IDX_W-1:0];
  assign probe_idx = probe_addr[IDX_W-1:0];

  // Debug probe reads the array directly; out-of-range addresses read as zero
  assign probe_data = probe_in ? mem[probe_idx] : 32'd0;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state: accept in IDLE, count down in WAIT, single-cycle RESP ignores req
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (req) state_next = S_WAIT;
      S_WAIT:  if (cnt == 4'd0) state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Request latch, wait counter and registered response outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt    <= 4'd0;
      we_q   <= 1'b0;
      addr_q <= '0;
      wd_q   <= 32'd0;
      rd     <= 32'd0;
      ack    <= 1'b0;
      busy   <= 1'b0;
      err    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req) begin
            we_q   <= we;
            addr_q <= addr;
            wd_q   <= wd;
            cnt    <= WS_L;
            busy   <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            ack <= 1'b1;
            if (in_range) begin
              if (!we_q) rd <= mem[idx_q];
            end else begin
              err <= 1'b1;
              if (!we_q) rd <= 32'd0;
            end
          end
        end
        S_RESP: begin
          ack  <= 1'b0;
          err  <= 1'b0;
          busy <= 1'b0;
        end
        default: begin
          ack  <= 1'b0;
          err  <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end

  // Array write on the access edge; contents are never reset, and a low reset blocks the write
  always_ff @(posedge clock) begin
    if (access && we_q && in_range && reset) mem[idx_q] <= wd_q;
  end

endmodule
